// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: default sizes, FSM encoding
// and the address range check used by the datapath and the BRAM wrapper.
package mem_responder_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ADDR_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  // Any address bit at or above the BRAM address width makes the access invalid.
  function automatic logic addr_out_of_range(input logic [31:0] a, input int abits);
    return ((a >> abits) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Datapath request/response bus plus BRAM port A signals of the memory responder.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
);

  logic                 req;
  logic                 wr;
  logic [WIDTH-1:0]     addr;
  logic [WIDTH-1:0]     wdata;
  logic                 ready;
  logic                 ack;
  logic                 err;
  logic [WIDTH-1:0]     rdata;
  logic [ADDR_BITS-1:0] bram_addr;
  logic [WIDTH-1:0]     bram_data;
  logic                 bram_we;
  logic [WIDTH-1:0]     bram_q;

  // Environment side: datapath requester together with the BRAM read port.
  modport master (
    output req, wr, addr, wdata, bram_q,
    input  ready, ack, err, rdata, bram_addr, bram_data, bram_we
  );

  modport slave (
    input  req, wr, addr, wdata, bram_q,
    output ready, ack, err, rdata, bram_addr, bram_data, bram_we
  );

endinterface

// File: rtl/mem_responder.sv
// Single-request memory responder: accepts one load/store at a time from the
// datapath, range-checks it and performs it on a registered-read BRAM port.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);

  state_t           state_r;
  state_t           next_state_s;

  logic             wr_r;
  logic [WIDTH-1:0] addr_r;
  logic [WIDTH-1:0] wdata_r;
  logic [WIDTH-1:0] rdata_r;

  logic             ready_r;
  logic             ack_r;
  logic             err_r;
  logic             bram_we_r;

  logic             ready_s;
  logic             ack_s;
  logic             err_s;
  logic             bram_we_s;

  logic             accept_s;
  logic             req_oor_s;
  logic             held_oor_s;

  assign accept_s   = (state_r == ST_IDLE) && bus.req;
  assign req_oor_s  = addr_out_of_range(32'(bus.addr), ADDR_BITS);
  assign held_oor_s = addr_out_of_range(32'(addr_r), ADDR_BITS);

  // State, request latches and output flops; reset clears every output at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      wr_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rdata_r   <= '0;
      ready_r   <= 1'b1;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      bram_we_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      ready_r   <= ready_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
      bram_we_r <= bram_we_s;
      if (accept_s) begin
        wr_r    <= bus.wr;
        addr_r  <= bus.addr;
        wdata_r <= bus.wdata;
      end
      // bram_q answers the address presented in RD, so it is valid by RD_WAIT.
      if (state_r == ST_RD_WAIT) begin
        rdata_r <= bus.bram_q;
      end
    end
  end

  // Next-state decision.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!bus.req) begin
          next_state_s = ST_IDLE;
        end else if (req_oor_s) begin
          next_state_s = ST_ACK;
        end else if (bus.wr) begin
          next_state_s = ST_WR;
        end else begin
          next_state_s = ST_RD;
        end
      end
      ST_WR:      next_state_s = ST_ACK;
      ST_RD:      next_state_s = ST_RD_WAIT;
      ST_RD_WAIT: next_state_s = ST_ACK;
      ST_ACK:     next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Outputs for the state being entered, so the flops line up with the state.
  always_comb begin
    ready_s   = (next_state_s == ST_IDLE);
    ack_s     = (next_state_s == ST_ACK);
    bram_we_s = (next_state_s == ST_WR);
    err_s     = 1'b0;
    if (next_state_s != ST_ACK) begin
      err_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      err_s = req_oor_s;
    end else begin
      err_s = held_oor_s && !wr_r && wr_r;
    end
  end

  assign bus.ready     = ready_r;
  assign bus.ack       = ack_r;
  assign bus.err       = err_r;
  assign bus.bram_we   = bram_we_r;
  assign bus.rdata     = rdata_r;
  assign bus.bram_addr = addr_r[ADDR_BITS-1:0];
  assign bus.bram_data = wdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, multi-cycle corner
// sequences and random traffic against a word-array reference model.
module tb_mem_responder;

  localparam int W  = 16;
  localparam int AB = 10;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_responder_if #(.WIDTH(W), .ADDR_BITS(AB)) bus ();

  mem_responder #(.WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM stand-in with registered read, not cleared by reset.
  logic [W-1:0] bram_mem [0:(1<<AB)-1];
  always @(posedge clk) begin
    if (bus.bram_we) bram_mem[bus.bram_addr] <= bus.bram_data;
    bus.bram_q <= bram_mem[bus.bram_addr];
  end

  // Reference model: word store keyed by full address, plus last load result.
  logic [W-1:0] model_mem [int];
  logic [W-1:0] last_rdata;

  function automatic logic [W-1:0] model_read(input int a);
    if (model_mem.exists(a)) return model_mem[a];
    return 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Issue one request and follow it to its ack, checking timing and outputs.
  task automatic run_txn(input logic w, input logic [W-1:0] a, input logic [W-1:0] d,
                         input logic [W-1:0] exp_rd, input logic exp_e, input int exp_lat,
                         input string nm);
    int   n;
    int   wes;
    logic seen;
    logic stray_err;
    @(negedge clk);
    chk({nm, "_ready_idle"}, 32'(bus.ready), 32'd1);
    chk({nm, "_ack_idle"}, 32'(bus.ack), 32'd0);
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    n = 0; wes = 0; seen = 1'b0; stray_err = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (bus.err && !bus.ack) stray_err = 1'b1;
      if (bus.bram_we) begin
        wes++;
        chk({nm, "_bram_addr"}, 32'(bus.bram_addr), 32'(a[AB-1:0]));
        chk({nm, "_bram_data"}, 32'(bus.bram_data), 32'(d));
      end
      if (bus.ack) begin
        seen = 1'b1;
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        chk({nm, "_err"}, 32'(bus.err), 32'(exp_e));
        chk({nm, "_rdata"}, 32'(bus.rdata), 32'(exp_rd));
        chk({nm, "_ready_ack"}, 32'(bus.ready), 32'd0);
      end
    end
    chk({nm, "_ack_seen"}, 32'(seen), 32'd1);
    chk({nm, "_we_cycles"}, 32'(wes), (w && !exp_e) ? 32'd1 : 32'd0);
    chk({nm, "_err_without_ack"}, 32'(stray_err), 32'd0);
  endtask

  typedef struct {
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp_rdata;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int acks;
    int ack_pos [$];
    int bad_ready;

    checks = 0; failures = 0;
    last_rdata = 16'h0000;
    for (int i = 0; i < (1 << AB); i++) bram_mem[i] = 16'h0000;

    vecs[0]  = '{1'b1, 16'h0000, 16'h000F, 16'h0000, 1'b0, 2};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 16'h000F, 1'b0, 3};
    vecs[2]  = '{1'b1, 16'h0002, 16'h3000, 16'h000F, 1'b0, 2};
    vecs[3]  = '{1'b1, 16'h03FF, 16'h0C00, 16'h000F, 1'b0, 2};
    vecs[4]  = '{1'b0, 16'h03FF, 16'h0000, 16'h0C00, 1'b0, 3};
    vecs[5]  = '{1'b0, 16'h0002, 16'h0000, 16'h3000, 1'b0, 3};
    vecs[6]  = '{1'b0, 16'h0400, 16'h0000, 16'h3000, 1'b1, 1};
    vecs[7]  = '{1'b1, 16'h0007, 16'h00F0, 16'h3000, 1'b0, 2};
    vecs[8]  = '{1'b0, 16'h0007, 16'h0000, 16'h00F0, 1'b0, 3};
    vecs[9]  = '{1'b1, 16'h0001, 16'h1234, 16'h00F0, 1'b0, 2};
    vecs[10] = '{1'b0, 16'h0001, 16'h0000, 16'h1234, 1'b0, 3};
    vecs[11] = '{1'b1, 16'hFFFF, 16'h5A5A, 16'h1234, 1'b1, 1};

    reset = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_we", 32'(bus.bram_we), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
    chk("rst_bram_data", 32'(bus.bram_data), 32'd0);
    reset = 1'b0;

    // First request lands on the first rising edge after reset release.
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
              vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
      if (vecs[i].wr && !vecs[i].exp_err) model_mem[int'(vecs[i].addr)] = vecs[i].wdata;
      last_rdata = vecs[i].exp_rdata;
    end

    // req held high across three stores.
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 16'h0010; bus.wdata = 16'hAAAA;
    acks = 0; bad_ready = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.ack) begin
        acks++;
        ack_pos.push_back(k);
        if (bus.ready) bad_ready++;
        if (acks == 3) bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    chk("hold_ack_count", 32'(acks), 32'd3);
    chk("hold_ready_in_ack", 32'(bad_ready), 32'd0);
    chk("hold_ack1", 32'(ack_pos.size() > 0 ? ack_pos[0] : -1), 32'd2);
    chk("hold_ack2", 32'(ack_pos.size() > 1 ? ack_pos[1] : -1), 32'd5);
    chk("hold_ack3", 32'(ack_pos.size() > 2 ? ack_pos[2] : -1), 32'd8);
    model_mem[16] = 16'hAAAA;
    run_txn(1'b0, 16'h0010, 16'h0000, 16'hAAAA, 1'b0, 3, "hold_readback");
    last_rdata = 16'hAAAA;

    // Reset in the middle of a write aborts it.
    run_txn(1'b1, 16'h0005, 16'h5555, last_rdata, 1'b0, 2, "pre_abort_store");
    model_mem[5] = 16'h5555;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 16'h0005; bus.wdata = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    chk("abort_we_before", 32'(bus.bram_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_we_async", 32'(bus.bram_we), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_ack", 32'(bus.ack), 32'd0);
    chk("abort_rdata", 32'(bus.rdata), 32'd0);
    chk("abort_bram_data", 32'(bus.bram_data), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    last_rdata = 16'h0000;
    run_txn(1'b0, 16'h0005, 16'h0000, 16'h5555, 1'b0, 3, "abort_readback");
    last_rdata = 16'h5555;

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      logic         w;
      logic [W-1:0] a;
      logic [W-1:0] d;
      logic         e;
      logic [W-1:0] er;
      int           sel;
      w   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 16'($urandom_range(1024, 65535));
      else if (sel == 1) a = 16'h03FF;
      else if (sel == 2) a = 16'h0400;
      else               a = 16'($urandom_range(0, 15));
      d  = 16'($urandom);
      e  = (int'(a) >= (1 << AB));
      er = (w || e) ? last_rdata : model_read(int'(a));
      run_txn(w, a, d, er, e, e ? 1 : (w ? 2 : 3), $sformatf("rnd%0d", i));
      if (w && !e) model_mem[int'(a)] = d;
      last_rdata = er;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WIDTH, 16, data width in bits.
REQ-002 Parameter ADDR_BITS, 10, BRAM address width; BRAM depth is 2**ADDR_BITS words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  datapath request; sampled only while ready=1.
REQ-006 wr  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  WIDTH  datapath word address; sampled with req.
REQ-008 wdata  input  WIDTH  store data; sampled with req.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 ack  output  1  one-cycle completion pulse.
REQ-011 err  output  1  high with ack when the request was out of range.
REQ-012 rdata  output  WIDTH  registered load result.
REQ-013 bram_addr  output  ADDR_BITS  to BRAM port A address.
REQ-014 bram_data  output  WIDTH  to BRAM port A write data.
REQ-015 bram_we  output  1  to BRAM port A write enable.
REQ-016 bram_q  input  WIDTH  from BRAM port A; valid one clock after bram_addr is presented (registered read).

Function
REQ-017 States: IDLE, WR, RD, RD_WAIT, ACK; binary encoded.
REQ-018 Acceptance: edge with state=IDLE and req=1 latches wr, addr, wdata; req is ignored in every other state.
REQ-019 Range check: addr[WIDTH-1:ADDR_BITS] nonzero -> go to ACK with err_pending=1; no BRAM access, rdata unchanged.
REQ-020 In-range store: IDLE -> WR (bram_we=1 for exactly one cycle) -> ACK -> IDLE; ack high the 2nd cycle after the acceptance edge.
REQ-021 In-range load: IDLE -> RD -> RD_WAIT -> ACK -> IDLE; rdata <= bram_q on the edge leaving RD_WAIT; ack high the 3rd cycle after the acceptance edge, with rdata valid in that same cycle.
REQ-022 bram_addr = latched addr[ADDR_BITS-1:0] and bram_data = latched wdata at all times; both hold their values between transactions.
REQ-023 bram_we is 1 only in WR and is never 1 for a load or an error.
REQ-024 ack and err are high only in ACK; err is 0 whenever ack is 0.
REQ-025 ready is 0 during the ACK cycle, so back-to-back requests start no earlier than the cycle after ACK.
REQ-026 rdata holds the last completed load value and is unaffected by stores and errors.
REQ-027 Address 2**ADDR_BITS-1 is valid; address 2**ADDR_BITS is the lowest erroring address.

Reset
REQ-028 Asserting reset, at any time, immediately forces: state=IDLE, ready=1, ack=0, err=0, bram_we=0, rdata=0, latched addr/wdata/wr=0.
REQ-029 Reset during WR aborts the write, because bram_we drops asynchronously; reset during RD or RD_WAIT discards the load and produces no ack.
REQ-030 The first acceptance is possible on the first rising edge after reset deasserts.

Structure
REQ-031 State encodings, WIDTH, and ADDR_BITS defaults live in the shared project defines header used by datapath and bram.
REQ-032 The block has no sub-modules; the bram is instantiated alongside it at top level, not inside it.
REQ-033 The block is a single FSM plus its latch registers, written as separate sequential and combinational blocks.

Verification
REQ-034 Store 0x000F to addr 0x0000, then load 0x0000 -> bram_we high for one cycle, ack at +2, then rdata=0x000F with ack at +3, err=0 throughout.
REQ-035 Stores 0x3000 to 0x0002 and 0x0C00 to 0x03FF, then loads in reverse order -> rdata=0x0C00, then 0x3000.
REQ-036 Load from addr 0x0400 -> ack with err=1 at +1 (state ACK), bram_we never asserted, rdata keeps its previous value.
REQ-037 req held high continuously for 3 stores -> exactly 3 acks, each acceptance one cycle after the previous ACK, ready=0 during every ACK cycle.
REQ-038 Reset asserted mid-WR of 0xFFFF to addr 0x0005 -> bram_we drops immediately; a later load of 0x0005 returns the pre-reset contents; no ack is produced for the aborted store.
REQ-039 Store 0x1234 to 0x0001 after a load of 0x00F0 -> rdata stays 0x00F0 until the next load completes.
